// File: rtl/snail_scan_ctrl.sv
// rtl/snail_scan_ctrl.sv - serial scan controller with programmable pattern detector
// Optional abort input enabled by defining SCAN_ABORT_EN.
module snail_scan_ctrl #(
  parameter int WIDTH   = 16,
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
`ifdef SCAN_ABORT_EN
  input  logic               abort,
`endif
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   word;
  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic               ovl;
  logic [IW-1:0]      idx;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_inc;
  logic               hit;
  logic               abort_req;
  logic               last_bit;

`ifdef SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_bit = (idx == IW'(WIDTH - 1)) || abort_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The word shifts left as it is emitted, so the current bit is always the MSB.
  assign ser_bit  = ser_valid & word[WIDTH-1];
  assign hist_nxt = {hist[PAT_LEN-2:0], word[WIDTH-1]};
  assign fill_inc = (fill == FW'(PAT_LEN)) ? fill : fill + FW'(1);
  assign hit      = (fill_inc == FW'(PAT_LEN)) && (hist_nxt == pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word      <= '0;
      pat       <= '0;
      ovl       <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      idx       <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            word      <= din;
            pat       <= pattern;
            ovl       <= overlap;
            hist      <= '0;
            fill      <= '0;
            idx       <= '0;
            match_cnt <= '0;
          end
        end
        SHIFT: begin
          word <= word << 1;
          idx  <= idx + IW'(1);
          hist <= hist_nxt;
          // Non-overlapping mode demands PAT_LEN fresh bits after every hit.
          fill <= (hit && !ovl) ? '0 : fill_inc;
          if (hit) begin
            match <= 1'b1;
            if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/snail_scan_ctrl.md
Name: snail_scan_ctrl

Overview:
- Scan controller for the serial sequence-detector datapath.
- Captures a parallel word, a programmable pattern and a mode on `start`, then serialises the word MSB-first, one bit per clock.
- Exports the serial stream (`ser_bit`/`ser_valid`) so an external hard-wired detector can run in lockstep.
- Runs its own programmable detector internally and reports per-match pulses, a saturating match count and `busy`/`done` status to the host.

Parameters:
- WIDTH, 16, bits per scanned word (>= PAT_LEN)
- PAT_LEN, 3, pattern length in bits (>= 2)
- CNT_W, 5, width of match counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  launch scan; sampled only in IDLE
- din  input  WIDTH  word to scan, captured on accepted start
- pattern  input  PAT_LEN  pattern to detect, MSB = first bit in time; captured on accepted start
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; captured on accepted start
- ser_bit  output  1  current serial bit
- ser_valid  output  1  ser_bit valid this cycle
- match  output  1  one-cycle pulse per detected pattern
- match_cnt  output  CNT_W  matches in current/last scan
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse at end of scan

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; word/pattern/history/fill/index registers cleared. Reset mid-scan abandons the scan immediately, with no done pulse.
- States and transitions:
  - IDLE: start=1 captures din/pattern/overlap, clears match_cnt, idx=0, fill=0, goes to SHIFT.
  - SHIFT: ser_valid=1, ser_bit=word[WIDTH-1-idx], busy=1, idx increments each cycle. After the idx=WIDTH-1 bit, goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, ser_valid=0; goes to IDLE.
- Latency: start sampled at edge 0 → first bit (din[WIDTH-1]) valid in cycle 1 → last bit in cycle WIDTH → done in cycle WIDTH+1.
- Detection:
  - History register shifts in each emitted bit. fill counts valid history bits, saturating at PAT_LEN.
  - A hit exists when the last PAT_LEN emitted bits (oldest = MSB) equal the captured pattern and fill has reached PAT_LEN including the current bit.
  - match is registered: it pulses in the cycle after the bit completing the pattern. A hit on the final bit therefore pulses match in the DONE cycle.
  - overlap=0: a hit resets fill to 0, so the next hit needs PAT_LEN fresh bits. overlap=1: fill is untouched.
- match_cnt:
  - Increments in the same cycle match is asserted.
  - Saturates at 2^CNT_W-1.
  - Holds its value through IDLE until the next accepted start.
- Boundary cases:
  - start in SHIFT or DONE is ignored; no re-capture.
  - start held high through DONE is accepted in the following IDLE cycle.
  - Changes on din/pattern/overlap after capture have no effect.
  - A fully-zero word still runs WIDTH cycles and pulses done.

Optional Feature:
- Macro: SCAN_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in SHIFT: the current cycle's bit is still emitted and evaluated; next state is DONE.
  - done pulses; match_cnt keeps the count accumulated so far, plus any match from that last bit.
  - abort is ignored in IDLE/DONE.
- Undefined: no abort port; every scan always emits exactly WIDTH bits.

Test Plan:
1. pattern=3'b110, overlap=1, din=16'b1101_1000_0000_0110, start at cycle 0 → bits in cycles 1–16, match pulses in cycles 4, 7, 17, done in cycle 17, match_cnt=3.
2. pattern=3'b111, din=16'hFFFF: overlap=1 → match_cnt=14, first match at cycle 4; overlap=0 → match_cnt=5 (matches at cycles 4, 7, 10, 13, 16).
3. CNT_W=3, pattern=3'b111, din=16'hFFFF, overlap=1 → match_cnt saturates at 7, match still pulses 14 times.
4. start re-asserted in cycles 5–8 with a different din → ignored, result identical to scenario 1. Then rst=1 at cycle 10 → all outputs 0 immediately, no done, IDLE afterwards.
5. din=16'h0000, pattern=3'b110 → ser_valid high for cycles 1–16, match never pulses, done at cycle 17, match_cnt=0.
6. SCAN_ABORT_EN defined, scenario 1 stimulus with abort=1 in cycle 6 → done in cycle 7, match pulses in cycles 4 and 7, match_cnt=2.
